red_pitaya_asg_sweep: RTL

Frequency-sweep sequencer for one ASG channel. It drives the 64-bit phase step (`set_step_i`/`set_step_lo_i`) of the channel through a programmed linear sweep, holding each point for a fixed dwell. It emits a one-cycle trigger at every point update, so the channel can latch the new step. It sits between the register bank and the ASG channel, one instance per channel, in the DAC clock domain.

---
 rtl/asg_sweep_pkg.sv | 20 ++
 rtl/red_pitaya_asg_sweep.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/asg_sweep_pkg.sv
// Shared types and constants for the ASG frequency-sweep sequencer.
package asg_sweep_pkg;

    // Default phase-step width of one ASG channel (high word + low word).
    localparam int STW_DEFAULT = 64;

    // Sweep shapes as programmed through the register bank.
    localparam logic [1:0] SWP_UP  = 2'd0;
    localparam logic [1:0] SWP_SAW = 2'd1;
    localparam logic [1:0] SWP_TRI = 2'd2;

    // STEP names the point-advance action. It shares its cycle with the
    // final DWELL cycle, so the register never rests in it.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/red_pitaya_asg_sweep.sv
// Linear frequency-sweep sequencer driving the phase step of one ASG channel.
// Each point is held for a programmed dwell. A one-cycle trigger marks every
// new point so the channel can latch it.
module red_pitaya_asg_sweep
    import asg_sweep_pkg::*;
#(
    parameter int STW = STW_DEFAULT
) (
    input  logic           dac_clk_i,
    input  logic           dac_rstn_i,
    input  logic           cfg_start_i,
    input  logic           cfg_stop_i,
    input  logic [STW-1:0] cfg_f0_i,
    input  logic [STW-1:0] cfg_f1_i,
    input  logic [STW-1:0] cfg_inc_i,
    input  logic [31:0]    cfg_dwell_i,
    input  logic [1:0]     cfg_mode_i,
    input  logic [15:0]    cfg_nrep_i,
    output logic [STW-1:0] step_o,
    output logic           trig_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [15:0]    rep_cnt_o,
    output logic           cfg_err_o
);

    sweep_state_t   state_q, state_d;
    logic [STW-1:0] step_q, step_d;
    logic [STW-1:0] f0_q, f0_d;
    logic [STW-1:0] f1_q, f1_d;
    logic [STW-1:0] inc_q, inc_d;
    logic [31:0]    dwellLoad_q, dwellLoad_d;
    logic [31:0]    dwellCnt_q, dwellCnt_d;
    logic [1:0]     mode_q, mode_d;
    logic [15:0]    nrep_q, nrep_d;
    logic [15:0]    repCnt_q, repCnt_d;
    logic           dirDown_q, dirDown_d;
    logic           trig_q, trig_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    logic           startReq;
    logic           startValid;
    logic           stopNow;
    logic           dwellLast;
    logic           upEnd;
    logic           downEnd;
    logic           repBump;
    logic           repMore;
    logic           finishNow;
    logic [15:0]    repInc;

    // Rising step, clamped to the upper bound; the extra bit catches wrap-around.
    function automatic logic [STW-1:0] clampAdd(input logic [STW-1:0] cur,
                                                input logic [STW-1:0] inc,
                                                input logic [STW-1:0] hi);
        logic [STW:0] sum;
        sum = {1'b0, cur} + {1'b0, inc};
        if (sum[STW] || (sum[STW-1:0] > hi)) begin
            return hi;
        end
        return sum[STW-1:0];
    endfunction

    // Falling step, clamped to the lower bound; the extra bit catches a borrow.
    function automatic logic [STW-1:0] clampSub(input logic [STW-1:0] cur,
                                                input logic [STW-1:0] inc,
                                                input logic [STW-1:0] lo);
        logic [STW:0] diff;
        diff = {1'b0, cur} - {1'b0, inc};
        if (diff[STW] || (diff[STW-1:0] < lo)) begin
            return lo;
        end
        return diff[STW-1:0];
    endfunction

    // Decode the events shared by the FSM and the datapath for this cycle.
    always_comb begin
        startReq   = cfg_start_i && !cfg_stop_i;
        startValid = (cfg_f1_i > cfg_f0_i) && (cfg_inc_i != '0);
        stopNow    = (state_q != IDLE) && cfg_stop_i;
        dwellLast  = (state_q == DWELL) && (dwellCnt_q == '0);
        upEnd      = !dirDown_q && (step_q == f1_q);
        downEnd    = dirDown_q && (step_q == f0_q);
        repInc     = repCnt_q + 16'd1;
        repMore    = (nrep_q == '0) || (repInc < nrep_q);
        repBump    = (upEnd && (mode_q == SWP_SAW)) || downEnd;
        finishNow  = dwellLast && ((upEnd && (mode_q == SWP_UP)) || (repBump && !repMore));
    end

    // State register.
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start enters DWELL, stop or sweep completion return to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (startReq && startValid) begin
                    state_d = DWELL;
                end
            end
            DWELL: begin
                if (stopNow || finishNow) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come straight from state and registers, so nothing glitches.
    always_comb begin
        busy_o    = (state_q != IDLE);
        step_o    = step_q;
        trig_o    = trig_q;
        done_o    = done_q;
        rep_cnt_o = repCnt_q;
        cfg_err_o = err_q;
    end

    // Datapath next values: shadow the config on start, then walk the legs.
    always_comb begin
        step_d      = step_q;
        f0_d        = f0_q;
        f1_d        = f1_q;
        inc_d       = inc_q;
        dwellLoad_d = dwellLoad_q;
        dwellCnt_d  = dwellCnt_q;
        mode_d      = mode_q;
        nrep_d      = nrep_q;
        repCnt_d    = repCnt_q;
        dirDown_d   = dirDown_q;
        err_d       = err_q;
        trig_d      = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (startReq) begin
                    if (startValid) begin
                        f0_d        = cfg_f0_i;
                        f1_d        = cfg_f1_i;
                        inc_d       = cfg_inc_i;
                        nrep_d      = cfg_nrep_i;
                        mode_d      = (cfg_mode_i == 2'd3) ? SWP_UP : cfg_mode_i;
                        dwellLoad_d = (cfg_dwell_i == '0) ? '0 : cfg_dwell_i - 32'd1;
                        dwellCnt_d  = (cfg_dwell_i == '0) ? '0 : cfg_dwell_i - 32'd1;
                        step_d      = cfg_f0_i;
                        trig_d      = 1'b1;
                        repCnt_d    = '0;
                        err_d       = 1'b0;
                        dirDown_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            DWELL: begin
                if (stopNow) begin
                    done_d = 1'b1;
                end else if (finishNow) begin
                    done_d = 1'b1;
                    if (repBump) begin
                        repCnt_d = repInc;
                    end
                end else if (dwellLast) begin
                    trig_d     = 1'b1;
                    dwellCnt_d = dwellLoad_q;
                    if (repBump) begin
                        repCnt_d = repInc;
                    end
                    if (!dirDown_q) begin
                        if (!upEnd) begin
                            step_d = clampAdd(step_q, inc_q, f1_q);
                        end else if (mode_q == SWP_TRI) begin
                            dirDown_d = 1'b1;
                            step_d    = clampSub(f1_q, inc_q, f0_q);
                        end else begin
                            step_d = f0_q;
                        end
                    end else begin
                        if (!downEnd) begin
                            step_d = clampSub(step_q, inc_q, f0_q);
                        end else begin
                            dirDown_d = 1'b0;
                            step_d    = clampAdd(f0_q, inc_q, f1_q);
                        end
                    end
                end else begin
                    dwellCnt_d = dwellCnt_q - 32'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
        if (!dac_rstn_i) begin
            step_q      <= '0;
            f0_q        <= '0;
            f1_q        <= '0;
            inc_q       <= '0;
            dwellLoad_q <= '0;
            dwellCnt_q  <= '0;
            mode_q      <= SWP_UP;
            nrep_q      <= '0;
            repCnt_q    <= '0;
            dirDown_q   <= 1'b0;
            trig_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            step_q      <= step_d;
            f0_q        <= f0_d;
            f1_q        <= f1_d;
            inc_q       <= inc_d;
            dwellLoad_q <= dwellLoad_d;
            dwellCnt_q  <= dwellCnt_d;
            mode_q      <= mode_d;
            nrep_q      <= nrep_d;
            repCnt_q    <= repCnt_d;
            dirDown_q   <= dirDown_d;
            trig_q      <= trig_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

endmodule
